// File: rtl/alu_arbiter_seq.sv
// -----------------------------------------------------------------------------
// alu_arbiter_seq
//
// Shares one external combinational 4-bit ALU between two requesters.
// Requests are granted round-robin in IDLE, then sequenced through the ALU:
// add/sub take a single pass, a shift by N takes N passes of the ALU's
// shift-by-1 operation with the accumulator fed back every cycle. The result
// is returned on one response channel tagged with the requester id.
//
// Ports
//   clk                      clock, all state updates on the rising edge
//   rst                      synchronous active-high reset
//   req0_* / req1_*          request channels (valid/ready, a, b, op, cnt)
//                            op: 00 add, 01 sub, 10 shift left, 11 shift right
//                            cnt: shift amount, ignored for add/sub
//   alu_a, alu_b, alu_sel    drive the external ALU (zero outside EXEC)
//   alu_out                  combinational ALU result
//   rsp_valid/rsp_ready      response handshake
//   rsp_id                   requester that owns the response
//   rsp_data                 result
//   busy                     high while a request is in flight (EXEC or RESP)
// -----------------------------------------------------------------------------
module alu_arbiter_seq #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [1:0]        req0_op,
  input  logic [CNT_W-1:0]  req0_cnt,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [1:0]        req1_op,
  input  logic [CNT_W-1:0]  req1_cnt,

  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_out,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,

  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // op[1] set means a shift; the ALU select encoding equals the request op.
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_SHL = 2'b10;
  localparam logic [1:0] OP_SHR = 2'b11;

  state_t              state_q;
  state_t              state_d;
  logic                prio_q;   // requester favoured when both are valid
  logic [DATA_W-1:0]   acc_q;    // running result, fed back through the ALU
  logic [DATA_W-1:0]   b_q;
  logic [1:0]          op_q;
  logic [CNT_W-1:0]    cnt_q;    // remaining shift passes
  logic                id_q;

  logic                grant0;
  logic                grant1;
  logic                accept;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;
  logic [1:0]          sel_op;
  logic [CNT_W-1:0]    sel_cnt;
  logic                sel_shift_zero;
  logic                exec_last;

  // ---------------------------------------------------------------------------
  // Round-robin grant. A lone valid always wins; a tie goes to prio_q.
  // Grants are only exposed as ready while IDLE.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = (prio_q == 1'b0);
      grant1 = (prio_q == 1'b1);
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign req0_ready = (state_q == IDLE) && grant0;
  assign req1_ready = (state_q == IDLE) && grant1;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  // Fields of whichever requester holds the grant.
  always_comb begin
    sel_a   = req0_a;
    sel_b   = req0_b;
    sel_op  = req0_op;
    sel_cnt = req0_cnt;
    if (grant1) begin
      sel_a   = req1_a;
      sel_b   = req1_b;
      sel_op  = req1_op;
      sel_cnt = req1_cnt;
    end
  end

  // A zero-length shift needs no ALU pass: the operand is already the result.
  assign sel_shift_zero = sel_op[1] && (sel_cnt == '0);

  // add/sub finish after one pass; shifts after the pass made with cnt_q == 1.
  assign exec_last = !op_q[1] || (cnt_q == CNT_W'(1));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = sel_shift_zero ? RESP : EXEC;
        end
      end
      EXEC: begin
        if (exec_last) begin
          state_d = RESP;
        end
      end
      RESP: begin
        // Returning to IDLE first means no request is accepted on the same
        // edge as the response handshake.
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      acc_q   <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      cnt_q   <= '0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_q  <= sel_a;
            b_q    <= sel_b;
            op_q   <= sel_op;
            cnt_q  <= sel_cnt;
            id_q   <= grant1;
            // The requester just served loses the next tie.
            prio_q <= ~grant1;
          end
        end
        EXEC: begin
          acc_q <= alu_out;
          if (op_q[1]) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // ALU drive: only meaningful while executing, held at zero otherwise so the
  // ALU inputs do not toggle on idle cycles.
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = OP_ADD;
    if (state_q == EXEC) begin
      alu_a   = acc_q;
      alu_b   = b_q;
      alu_sel = op_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Response channel and status, decoded from registered state. acc_q and id_q
  // do not change while in RESP, so the response holds until accepted.
  // ---------------------------------------------------------------------------
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_valid ? acc_q : '0;
  assign rsp_id    = rsp_valid && id_q;
  assign busy      = (state_q != IDLE);

  // ---------------------------------------------------------------------------
  // Structural properties of the arbiter
  // ---------------------------------------------------------------------------
  a_ready_exclusive : assert property (@(posedge clk) disable iff (rst)
    !(req0_ready && req1_ready));

  a_ready_only_idle : assert property (@(posedge clk) disable iff (rst)
    busy |-> (!req0_ready && !req1_ready));

  // Shift ops only enter EXEC with a non-zero count.
  a_shift_cnt_nonzero : assert property (@(posedge clk) disable iff (rst)
    ((state_q == EXEC) && op_q[1]) |-> (cnt_q != '0));

  // Keep the select encodings referenced for readers of the waveform.
  logic unused_ops;
  assign unused_ops = ^{OP_SUB, OP_SHL, OP_SHR};

endmodule

// File: doc/alu_arbiter_seq.md
Name: alu_arbiter_seq

Overview:
Shares one 4-bit `alu` instance between two requesters using round-robin arbitration and a valid/ready handshake. Each accepted request is sequenced through the ALU: add and sub take one ALU pass; shifts by N take N passes of the ALU's shift-by-1 op, with the result fed back each cycle. The result returns on a single response channel tagged with the requester id. The block sits between the two datapath clients and the combinational ALU.

Parameters:
DATA_W, 4, operand/result width; fixed at 4 to match the ALU.
CNT_W, 2, width of the shift-count field; shift amount 0..3.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
req0_valid  in  1  requester 0 has a request.
req0_ready  out  1  request 0 accepted this cycle when high with req0_valid.
req0_a  in  DATA_W  operand A.
req0_b  in  DATA_W  operand B.
req0_op  in  2  00 add, 01 sub, 10 shift left, 11 shift right.
req0_cnt  in  CNT_W  shift amount; ignored for add/sub.
req1_valid, req1_ready, req1_a, req1_b, req1_op, req1_cnt  same as requester 0, for requester 1.
alu_a  out  DATA_W  to ALU input A.
alu_b  out  DATA_W  to ALU input B.
alu_sel  out  2  to ALU select.
alu_out  in  DATA_W  ALU result (combinational).
rsp_valid  out  1  response available.
rsp_ready  in  1  consumer accepts response.
rsp_id  out  1  id of requester owning the response.
rsp_data  out  DATA_W  result.
busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (synchronous, rst=1 at edge):
  - State goes to IDLE and the priority pointer to requester 0.
  - Internal acc, b_reg, op_reg, cnt_reg and id_reg clear to 0.
  - rsp_valid, rsp_id and rsp_data clear to 0.
  - Reset mid-operation abandons the request; no response is produced.
- States: IDLE, EXEC, RESP.
- Grant (combinational, IDLE only):
  - If only one valid is high, that requester is granted.
  - If both are high, the requester at the priority pointer is granted.
  - reqN_ready = (state==IDLE) && grantN.
  - Both ready outputs are 0 in EXEC and RESP.
- Accept (IDLE, valid&&ready):
  - Capture acc<=a, b_reg, op_reg, cnt_reg, id_reg.
  - Pointer <= the other requester.
  - Next state is EXEC, except shift with cnt==0, which goes directly to RESP with rsp_data=a.
- Requesters must hold fields stable while valid && !ready. Dropping valid before acceptance is legal; nothing is captured.
- EXEC:
  - alu_a=acc, alu_b=b_reg, alu_sel=op_reg; acc<=alu_out each cycle.
  - add/sub: exactly one EXEC cycle, then RESP.
  - Shifts: cnt_reg decrements each cycle; leave EXEC after the cycle in which cnt_reg==1.
  - Outside EXEC, alu_a, alu_b and alu_sel are driven to 0.
- Arithmetic: modulo 2^DATA_W (ALU wrap). Shifts are logical, zero-filled.
- RESP:
  - rsp_valid=1; rsp_data=acc and rsp_id=id_reg, held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, next state is IDLE.
  - A new request cannot be accepted in the same cycle as the response handshake.
- Latency, accept edge to first rsp_valid cycle:
  - add/sub: 2 cycles.
  - Shift by n>0: n+1 cycles.
  - Shift by 0: 1 cycle.
- busy: registered state decode, high in EXEC and RESP.

Test Plan:
1. Hold rst=1 for 2 cycles with both valids high -> rsp_valid=0, rsp_data=0, busy=0, alu_sel=0; first grant after rst goes to requester 0.
2. req0 a=9 b=8 op=00 -> rsp_data=1 (wrap), rsp_id=0, rsp_valid 2 cycles after accept. Then req1 a=3 b=5 op=01 -> rsp_data=14, rsp_id=1.
3. req0 op=10 a=0011 cnt=3 -> alu_sel=10 for 3 EXEC cycles, rsp_data=1000, 4 cycles after accept. req1 op=11 a=1010 cnt=0 -> rsp_data=1010, 1 cycle after accept, no EXEC cycle.
4. Both valids held high, rsp_ready=1, 6 requests -> rsp_id sequence 0,1,0,1,0,1.
5. rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_data and rsp_id stable; req0_ready and req1_ready stay 0; completes on the cycle rsp_ready rises.
6. rst asserted during the second EXEC cycle of a cnt=3 shift -> next cycle IDLE, busy=0, no rsp_valid. A following req1 add 2+2 -> rsp_data=4.
